// File: rtl/zdos_pkg.sv
// zdos_pkg: shared definitions for the TR-DOS entry/exit trap.
//   state_e        FSM encoding (IDLE / DECIDE / HOLD)
//   TRAP_PAGE_DEF  default high address byte that arms DOS turn-on
//   RAM_BOUND_DEF  default za[15:14] threshold for a RAM fetch
//   NMI_VECTOR     Z80 NMI entry address
package zdos_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDecide = 2'd1,
        StHold   = 2'd2
    } state_e;

    localparam logic [7:0]  TRAP_PAGE_DEF = 8'h3D;
    localparam logic [1:0]  RAM_BOUND_DEF = 2'b01;
    localparam logic [15:0] NMI_VECTOR    = 16'h0066;

endpackage

// File: rtl/zdos_trap_if.sv
// zdos_trap_if: Z80 bus sampling inputs and DOS-controller request outputs of zdos_trap.
//   master modport: bus/controller side (drives Z80 signals, receives pulses)
//   slave modport : zdos_trap side
//   Signals: zpos, za[15:0], m1_n, mreq_n, rfsh_n, basic48, dos, cpm_n, nmi_pend (to trap);
//            dos_turn_on, dos_turn_off, m1_fetch (from trap).
interface zdos_trap_if;
    logic        zpos;
    logic [15:0] za;
    logic        m1_n;
    logic        mreq_n;
    logic        rfsh_n;
    logic        basic48;
    logic        dos;
    logic        cpm_n;
    logic        nmi_pend;
    logic        dos_turn_on;
    logic        dos_turn_off;
    logic        m1_fetch;

    modport master (
        output zpos, za, m1_n, mreq_n, rfsh_n, basic48, dos, cpm_n, nmi_pend,
        input  dos_turn_on, dos_turn_off, m1_fetch
    );

    modport slave (
        input  zpos, za, m1_n, mreq_n, rfsh_n, basic48, dos, cpm_n, nmi_pend,
        output dos_turn_on, dos_turn_off, m1_fetch
    );
endinterface

// File: rtl/zdos_trap_decode.sv
// zdos_trap_decode: combinational decision for one latched opcode fetch.
//   addr_i, basic48_i, dos_i, cpm_n_i, nmi_pend_i : snapshot taken at the qualifying zpos
//   turn_on_o / turn_off_o                        : DOS on / off request (never both)
// Optional feature: ZDOS_NMI_TRAP_EN enables NMI-vector entry into DOS.
module zdos_trap_decode
    import zdos_pkg::*;
#(
    parameter logic [7:0] TrapPage = TRAP_PAGE_DEF,
    parameter logic [1:0] RamBound = RAM_BOUND_DEF
) (
    input  logic [15:0] addr_i,
    input  logic        basic48_i,
    input  logic        dos_i,
    input  logic        cpm_n_i,
    input  logic        nmi_pend_i,
    output logic        turn_on_o,
    output logic        turn_off_o
);

    logic rom_trap;
    logic nmi_trap;

    assign rom_trap = basic48_i & (addr_i[15:8] == TrapPage);

`ifdef ZDOS_NMI_TRAP_EN
    // Magic/NMI entry: DOS ROM is forced in regardless of which ROM page is mapped.
    assign nmi_trap = nmi_pend_i & (addr_i == NMI_VECTOR);
`else
    logic unused_nmi;
    assign unused_nmi = ^{nmi_pend_i, addr_i[7:0]};
    assign nmi_trap   = 1'b0;
`endif

    // dos selects which condition may fire, so the two outputs are exclusive.
    assign turn_on_o  = cpm_n_i & ~dos_i & (rom_trap | nmi_trap);
    assign turn_off_o = cpm_n_i & dos_i & (addr_i[15:14] >= RamBound);

endmodule

// File: rtl/zdos_trap.sv
// zdos_trap: watches Z80 M1 opcode fetches and emits one-fclk dos_turn_on / dos_turn_off
// requests; one decision per M1 cycle.
//   fclk  : system clock
//   rst_n : synchronous active-low reset
//   bus   : zdos_trap_if.slave (Z80 sampling inputs, pulse outputs)
// Optional feature: ZDOS_NMI_TRAP_EN (see zdos_trap_decode).
module zdos_trap
    import zdos_pkg::*;
#(
    parameter logic [7:0] TrapPage = TRAP_PAGE_DEF,
    parameter logic [1:0] RamBound = RAM_BOUND_DEF
) (
    input  logic        fclk,
    input  logic        rst_n,
    zdos_trap_if.slave  bus
);

    state_e      state_q;
    logic [15:0] addr_q;
    logic        basic48_q;
    logic        dos_q;
    logic        cpm_n_q;
    logic        nmi_pend_q;
    logic        on_q;
    logic        off_q;
    logic        fetch_q;

    logic        fetch_qual;
    logic        dec_on;
    logic        dec_off;

    // Opcode fetch: M1 with MREQ outside refresh; interrupt acknowledge has MREQ high.
    assign fetch_qual = bus.zpos & ~bus.m1_n & ~bus.mreq_n & bus.rfsh_n;

    zdos_trap_decode #(
        .TrapPage (TrapPage),
        .RamBound (RamBound)
    ) u_decode (
        .addr_i     (addr_q),
        .basic48_i  (basic48_q),
        .dos_i      (dos_q),
        .cpm_n_i    (cpm_n_q),
        .nmi_pend_i (nmi_pend_q),
        .turn_on_o  (dec_on),
        .turn_off_o (dec_off)
    );

    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            basic48_q  <= 1'b0;
            dos_q      <= 1'b0;
            cpm_n_q    <= 1'b1;
            nmi_pend_q <= 1'b0;
            on_q       <= 1'b0;
            off_q      <= 1'b0;
            fetch_q    <= 1'b0;
        end else begin
            on_q    <= 1'b0;
            off_q   <= 1'b0;
            fetch_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (fetch_qual) begin
                        addr_q     <= bus.za;
                        basic48_q  <= bus.basic48;
                        dos_q      <= bus.dos;
                        cpm_n_q    <= bus.cpm_n;
                        nmi_pend_q <= bus.nmi_pend;
                        state_q    <= StDecide;
                    end
                end
                StDecide: begin
                    on_q    <= dec_on;
                    off_q   <= dec_off;
                    fetch_q <= 1'b1;
                    state_q <= StHold;
                end
                StHold: begin
                    // Only a zpos with M1 released ends the cycle; no re-decision before.
                    if (bus.zpos && bus.m1_n) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.dos_turn_on  = on_q;
    assign bus.dos_turn_off = off_q;
    assign bus.m1_fetch     = fetch_q;

endmodule

// File: tb/tb_zdos_trap.sv
module tb_zdos_trap;

    logic fclk;
    logic rst_n;
    int unsigned cyc;
    int n_tests;
    int n_fail;
    logic started;

    typedef struct {
        int unsigned cyc;
        logic [2:0]  val;   // {dos_turn_on, dos_turn_off, m1_fetch}
    } exp_t;

    exp_t exp_q[$];

    zdos_trap_if bus ();

    zdos_trap dut (
        .fclk  (fclk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    initial cyc = 0;
    always @(posedge fclk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard whenever the DUT presents a pulse, and flags
    // expected pulses that never showed up.
    always @(negedge fclk) begin
        logic [2:0] got;
        exp_t e;
        got = {bus.dos_turn_on, bus.dos_turn_off, bus.m1_fetch};
        if (started) begin
            if (got != 3'b000) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse cyc=%0d got=%b required=none", cyc, got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e.val || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL pulse cyc=%0d got=%b required cyc=%0d val=%b",
                                 cyc, got, e.cyc, e.val);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                n_tests++;
                n_fail++;
                e = exp_q.pop_front();
                $display("FAIL missing_pulse cyc=%0d got=000 required=%b", cyc, e.val);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge fclk);
    endtask

    // Release M1 and end the cycle with a zpos during refresh.
    task automatic release_m1();
        @(negedge fclk);
        bus.m1_n   = 1'b1;
        bus.mreq_n = 1'b1;
        bus.rfsh_n = 1'b0;
        bus.zpos   = 1'b1;
        @(negedge fclk);
        bus.zpos   = 1'b0;
        bus.rfsh_n = 1'b1;
        idle(2);
    endtask

    // One complete M1 opcode fetch; val is the expected {on,off,fetch} pulse.
    task automatic fetch(input logic [15:0] a, input logic [2:0] val);
        exp_t e;
        @(negedge fclk);
        bus.za     = a;
        bus.m1_n   = 1'b0;
        bus.mreq_n = 1'b0;
        bus.rfsh_n = 1'b1;
        bus.zpos   = 1'b1;
        e.cyc = cyc + 2;
        e.val = val;
        exp_q.push_back(e);
        @(negedge fclk);
        bus.zpos = 1'b0;
        idle(3);
        release_m1();
    endtask

    task automatic check_idle_outputs(input string name);
        logic [2:0] got;
        got = {bus.dos_turn_on, bus.dos_turn_off, bus.m1_fetch};
        n_tests++;
        if (got !== 3'b000) begin
            n_fail++;
            $display("FAIL %s got=%b required=000", name, got);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        started = 1'b0;
        rst_n        = 1'b0;
        bus.zpos     = 1'b0;
        bus.za       = 16'h0000;
        bus.m1_n     = 1'b1;
        bus.mreq_n   = 1'b1;
        bus.rfsh_n   = 1'b1;
        bus.basic48  = 1'b0;
        bus.dos      = 1'b0;
        bus.cpm_n    = 1'b1;
        bus.nmi_pend = 1'b0;
        idle(3);
        check_idle_outputs("reset_outputs");
        rst_n   = 1'b1;
        started = 1'b1;
        idle(2);

        // 1: TR-DOS entry from 48 BASIC
        bus.dos = 1'b0; bus.basic48 = 1'b1;
        fetch(16'h3D2F, 3'b101);
        fetch(16'h3C00, 3'b001);   // neighbouring page: no trap
        fetch(16'h8000, 3'b001);   // RAM but DOS already off

        // 2: TR-DOS exit on RAM fetch
        bus.dos = 1'b1;
        fetch(16'h8000, 3'b011);
        fetch(16'h1234, 3'b001);
        fetch(16'h4000, 3'b011);   // lowest RAM address
        fetch(16'h3FFF, 3'b001);   // highest ROM address
        fetch(16'h3D00, 3'b001);   // trap page with DOS on: nothing

        // 3: trap page without 48 BASIC mapped
        bus.dos = 1'b0; bus.basic48 = 1'b0;
        fetch(16'h3D00, 3'b001);

        // 4: CP/M suppresses both pulses
        bus.cpm_n = 1'b0; bus.dos = 1'b1;
        fetch(16'hC000, 3'b001);
        bus.dos = 1'b0; bus.basic48 = 1'b1;
        fetch(16'h3D10, 3'b001);
        bus.cpm_n = 1'b1;

        // Interrupt acknowledge (MREQ high) is not a fetch.
        @(negedge fclk);
        bus.za = 16'h3D00; bus.m1_n = 1'b0; bus.mreq_n = 1'b1; bus.zpos = 1'b1;
        @(negedge fclk);
        bus.zpos = 1'b0;
        idle(3);
        release_m1();

        // Fetch qualifier without zpos is ignored.
        @(negedge fclk);
        bus.za = 16'h3D00; bus.m1_n = 1'b0; bus.mreq_n = 1'b0;
        idle(4);
        bus.m1_n = 1'b1; bus.mreq_n = 1'b1;
        idle(3);

        // Extra zpos while M1 is still low must not re-decide.
        bus.dos = 1'b1;
        @(negedge fclk);
        bus.za = 16'h8000; bus.m1_n = 1'b0; bus.mreq_n = 1'b0; bus.zpos = 1'b1;
        begin
            exp_t e;
            e.cyc = cyc + 2;
            e.val = 3'b011;
            exp_q.push_back(e);
        end
        @(negedge fclk); bus.zpos = 1'b0;
        idle(3);
        bus.zpos = 1'b1;
        @(negedge fclk); bus.zpos = 1'b0;
        // M1 rises without zpos: still HOLD, a new qualifier on the same zpos-less path is ignored.
        bus.m1_n = 1'b1; bus.mreq_n = 1'b1;
        idle(3);
        release_m1();

        // 5: reset while in DECIDE
        bus.dos = 1'b0; bus.basic48 = 1'b1;
        @(negedge fclk);
        bus.za = 16'h3D00; bus.m1_n = 1'b0; bus.mreq_n = 1'b0; bus.zpos = 1'b1;
        @(negedge fclk);
        bus.zpos = 1'b0;
        rst_n    = 1'b0;
        @(negedge fclk);
        rst_n = 1'b1;
        check_idle_outputs("reset_in_decide_a");
        @(negedge fclk);
        check_idle_outputs("reset_in_decide_b");
        bus.m1_n = 1'b1; bus.mreq_n = 1'b1;
        idle(2);
        fetch(16'h3D00, 3'b101);   // decided normally after reset

        // 6: NMI vector
        bus.dos = 1'b0; bus.basic48 = 1'b0; bus.nmi_pend = 1'b1;
`ifdef ZDOS_NMI_TRAP_EN
        fetch(16'h0066, 3'b101);
`else
        fetch(16'h0066, 3'b001);
`endif
        bus.nmi_pend = 1'b0;
        fetch(16'h0066, 3'b001);

        idle(5);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d pending required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
